// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store sequencer.
//   Accepts one decoded load/store at a time, drives a req/gnt/rvalid data
//   memory bus with byte enables and lane-aligned write data, and returns
//   sign/zero-extended load data to writeback.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid / req_ready           operation handshake (ready only in IDLE)
//   mem_read, mem_write, funct3     decoded op strobes and size/sign
//   addr, store_data, rd            ALU address, rs2 data, load destination
//   dmem_req/we/addr/be/wdata       bus request (held until dmem_gnt)
//   dmem_gnt, dmem_rvalid, dmem_rdata  bus grant and read response
//   wb_valid, wb_rd, wb_data        load writeback pulse and payload
//   done, err                       completion pulse, error flag with done
//
// Configuration macro:
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned halfword/word accesses
//                          complete with err and never reach the bus; when
//                          undefined, alignment is forced by ignoring the
//                          low address bits.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned F3_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operation context needed after acceptance
  logic [F3_W-1:0]   f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [RD_W-1:0]   rd_q, rd_d;

  // Next values of the registered outputs
  logic              dmem_req_d;
  logic              dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_d;
  logic [BE_W-1:0]   dmem_be_d;
  logic [DATA_W-1:0] dmem_wdata_d;
  logic              wb_valid_d;
  logic [RD_W-1:0]   wb_rd_d;
  logic [DATA_W-1:0] wb_data_d;
  logic              done_d;
  logic              err_d;

  // Decode of the incoming operation
  logic              op_noop;
  logic              op_bad;
  logic              load_f3_ok;
  logic              store_f3_ok;
  logic              misalign;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_fmt;

  assign req_ready = (state_q == S_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Legal funct3 encodings per op type
  always_comb begin
    load_f3_ok  = 1'b0;
    store_f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin
        load_f3_ok  = 1'b1;
        store_f3_ok = 1'b1;
      end
      3'b100, 3'b101: load_f3_ok = 1'b1;
      default: ;
    endcase
  end

  assign op_noop = !mem_read && !mem_write;
  assign op_bad  = (mem_read && mem_write) ||
                   (mem_read && !load_f3_ok) ||
                   (mem_write && !store_f3_ok) ||
                   misalign;

  // Store lane placement; loads always request the full word
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = '0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          lane_be    = 4'b0001 << addr[1:0];
          lane_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          lane_be    = 4'b0011 << {addr[1], 1'b0};
          lane_wdata = {2{store_data[15:0]}};
        end
        default: lane_wdata = store_data;
      endcase
    end
  end

  // Load lane extraction and extension
  assign byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = dmem_rdata;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_be    <= dmem_be_d;
      dmem_wdata <= dmem_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_rd      <= wb_rd_d;
      wb_data    <= wb_data_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req;
    dmem_we_d    = dmem_we;
    dmem_addr_d  = dmem_addr;
    dmem_be_d    = dmem_be;
    dmem_wdata_d = dmem_wdata;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd;
    wb_data_d    = wb_data;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d  = funct3;
          off_d = addr[1:0];
          rd_d  = rd;
          if (op_noop) begin
            done_d = 1'b1;
          end else if (op_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d      = S_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            dmem_be_d    = lane_be;
            dmem_wdata_d = lane_wdata;
          end
        end
      end

      S_REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (dmem_we) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          done_d     = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_fmt;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed operations with a cycle-accurate
// expectation model derived from the access rules, one per-cycle compare
// process, and literal checks pinning the model on the key vectors.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-cycle expectations
  logic        e_ready, e_req, e_we, e_done, e_err, e_wbv, e_chk_wdata;
  logic [31:0] e_addr, e_wdata, e_wbdata;
  logic [3:0]  e_be;
  logic [4:0]  e_wbrd;
  bit          chk_en = 1'b0;

  // Observations for literal checks
  int          req_cycles = 0;
  logic [31:0] cap_addr, cap_wdata, last_wb_data;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [4:0]  last_wb_rd;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check32("req_ready", 32'(req_ready), 32'(e_ready));
      check32("dmem_req",  32'(dmem_req),  32'(e_req));
      check32("done",      32'(done),      32'(e_done));
      check32("err",       32'(err),       32'(e_err));
      check32("wb_valid",  32'(wb_valid),  32'(e_wbv));
      if (e_req) begin
        check32("dmem_we",   32'(dmem_we), 32'(e_we));
        check32("dmem_addr", dmem_addr,    e_addr);
        check32("dmem_be",   32'(dmem_be), 32'(e_be));
        if (e_chk_wdata) check32("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (e_wbv) begin
        check32("wb_rd",   32'(wb_rd), 32'(e_wbrd));
        check32("wb_data", wb_data,    e_wbdata);
      end
      if (dmem_req) begin
        req_cycles++;
        cap_addr  = dmem_addr;
        cap_be    = dmem_be;
        cap_wdata = dmem_wdata;
        cap_we    = dmem_we;
      end
      if (wb_valid) begin
        last_wb_data = wb_data;
        last_wb_rd   = wb_rd;
      end
    end
  end

  // ---------------- model of the access rules ----------------
  localparam int K_NOOP = 0, K_ERR = 1, K_LOAD = 2, K_STORE = 3;

  function automatic int classify(input logic rs, input logic ws,
                                  input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    bit mis;
    if (!rs && !ws) return K_NOOP;
    if (rs && ws) return K_ERR;
    if (rs) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    if (!legal) return K_ERR;
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) mis = 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) mis = 1'b1;
`endif
    if (mis) return K_ERR;
    return rs ? K_LOAD : K_STORE;
  endfunction

  function automatic logic [3:0] exp_be(input int kind, input logic [2:0] f3, input logic [31:0] a);
    int b;
    b = int'(a % 4);
    if (kind == K_LOAD || f3 == 3'd2) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << b);
    return (b >= 2) ? 4'b1100 : 4'b0011;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] v;
    if (f3 == 3'd0) v = (sd & 32'hFF) * 32'h0101_0101;
    else if (f3 == 3'd1) v = (sd & 32'hFFFF) * 32'h0001_0001;
    else v = sd;
    return v;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * int'(a % 4))) & 32'hFF;
    h = (rdata >> (16 * int'((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_exp();
    e_ready = 1'b1; e_req = 1'b0; e_done = 1'b0; e_err = 1'b0; e_wbv = 1'b0;
    e_we = 1'b0; e_chk_wdata = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b111; addr = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF; rd = 5'd0;
  endtask

  task automatic present(input logic rs, input logic ws, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    req_valid = 1'b1; mem_read = rs; mem_write = ws;
    funct3 = f3; addr = a; store_data = sd; rd = r;
  endtask

  // One complete operation; gd = extra grant wait cycles, rl = cycles from grant to rvalid
  task automatic run_op(input logic rs, input logic ws, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                        input int gd, input int rl, input logic [31:0] rdata);
    int kind;
    kind = classify(rs, ws, f3, a);
    present(rs, ws, f3, a, sd, r);
    idle_exp();
    req_cycles = 0;
    step();
    clear_req();
    if (kind == K_NOOP || kind == K_ERR) begin
      e_done = 1'b1;
      e_err  = (kind == K_ERR);
      step();
      idle_exp();
      return;
    end
    e_ready = 1'b0; e_req = 1'b1; e_we = (kind == K_STORE);
    e_addr = a & 32'hFFFF_FFFC;
    e_be = exp_be(kind, f3, a);
    e_wdata = exp_wdata(f3, sd);
    e_chk_wdata = (kind == K_STORE);
    for (int i = 0; i <= gd; i++) begin
      dmem_gnt = (i == gd);
      step();
    end
    dmem_gnt = 1'b0;
    e_req = 1'b0;
    if (kind == K_STORE) begin
      e_done = 1'b1; e_ready = 1'b1;
      step();
      idle_exp();
      return;
    end
    for (int j = 1; j <= rl; j++) begin
      dmem_rvalid = (j == rl);
      dmem_rdata  = (j == rl) ? rdata : 32'h5A5A_5A5A;
      step();
    end
    dmem_rvalid = 1'b0;
    e_wbv = 1'b1; e_done = 1'b1; e_ready = 1'b1;
    e_wbrd = r;
    e_wbdata = exp_load(f3, a, rdata);
    step();
    idle_exp();
  endtask

  // Idle cycle with a stray read response that must be ignored
  task automatic stray_rvalid(input logic [31:0] d);
    dmem_rvalid = 1'b1;
    dmem_rdata  = d;
    idle_exp();
    step();
    dmem_rvalid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b1;
    clear_req();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    idle_exp();
    e_addr = '0; e_wdata = '0; e_wbdata = '0; e_be = '0; e_wbrd = '0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    last_wb_data = '0; last_wb_rd = '0;
    #1 rst_n = 1'b0;
    #1;
    check32("rst_req_ready",  32'(req_ready),  32'd1);
    check32("rst_dmem_req",   32'(dmem_req),   32'd0);
    check32("rst_dmem_we",    32'(dmem_we),    32'd0);
    check32("rst_dmem_addr",  dmem_addr,       32'd0);
    check32("rst_dmem_be",    32'(dmem_be),    32'd0);
    check32("rst_dmem_wdata", dmem_wdata,      32'd0);
    check32("rst_wb_valid",   32'(wb_valid),   32'd0);
    check32("rst_wb_rd",      32'(wb_rd),      32'd0);
    check32("rst_wb_data",    wb_data,         32'd0);
    check32("rst_done",       32'(done),       32'd0);
    check32("rst_err",        32'(err),        32'd0);
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // LW zero-wait
    run_op(1, 0, 3'b010, 32'h100, 32'd0, 5'd5, 0, 1, 32'hDEAD_BEEF);
    check32("lw_addr_lit",  cap_addr,          32'h100);
    check32("lw_be_lit",    32'(cap_be),       32'hF);
    check32("lw_data_lit",  last_wb_data,      32'hDEAD_BEEF);
    check32("lw_rd_lit",    32'(last_wb_rd),   32'd5);

    // LB / LBU at byte 3
    run_op(1, 0, 3'b000, 32'h103, 32'd0, 5'd7, 0, 1, 32'h80FF_7F01);
    check32("lb_data_lit",  last_wb_data, 32'hFFFF_FF80);
    run_op(1, 0, 3'b100, 32'h103, 32'd0, 5'd8, 0, 2, 32'h80FF_7F01);
    check32("lbu_data_lit", last_wb_data, 32'h0000_0080);
    stray_rvalid(32'hCAFE_F00D);

    // SH with 3-cycle grant delay
    run_op(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0, 3, 1, 32'd0);
    check32("sh_be_lit",    32'(cap_be), 32'b1100);
    check32("sh_wdata_lit", cap_wdata,   32'hABCD_ABCD);
    check32("sh_we_lit",    32'(cap_we), 32'd1);
    check32("sh_req_cycles", 32'(req_cycles), 32'd4);

    // Misaligned LW
    run_op(1, 0, 3'b010, 32'h101, 32'd0, 5'd9, 0, 1, 32'h1122_3344);
`ifdef LSU_MISALIGN_CHECK_EN
    check32("lw_mis_no_req", 32'(req_cycles), 32'd0);
`else
    check32("lw_mis_addr_lit", cap_addr,     32'h100);
    check32("lw_mis_data_lit", last_wb_data, 32'h1122_3344);
`endif

    // Illegal store funct3
    run_op(0, 1, 3'b011, 32'h200, 32'h5555_AAAA, 5'd0, 0, 1, 32'd0);
    check32("st_illegal_no_req", 32'(req_cycles), 32'd0);

    // Store lanes
    run_op(0, 1, 3'b000, 32'h401, 32'h0000_00A5, 5'd0, 1, 1, 32'd0);
    check32("sb_be_lit", 32'(cap_be), 32'b0010);
    run_op(0, 1, 3'b000, 32'h402, 32'h1234_5677, 5'd0, 0, 1, 32'd0);
    run_op(0, 1, 3'b000, 32'h403, 32'hFFFF_FF3C, 5'd0, 2, 1, 32'd0);
    run_op(0, 1, 3'b001, 32'h400, 32'hDEAD_0102, 5'd0, 0, 1, 32'd0);
    run_op(0, 1, 3'b010, 32'h40C, 32'hCAFE_BABE, 5'd0, 0, 1, 32'd0);
    check32("sw_wdata_lit", cap_wdata, 32'hCAFE_BABE);

    // Load lanes and extension
    run_op(1, 0, 3'b001, 32'h206, 32'd0, 5'd10, 0, 1, 32'h8001_7FFF);
    check32("lh_hi_lit", last_wb_data, 32'hFFFF_8001);
    run_op(1, 0, 3'b101, 32'h206, 32'd0, 5'd11, 1, 3, 32'h8001_7FFF);
    run_op(1, 0, 3'b001, 32'h204, 32'd0, 5'd12, 0, 1, 32'h8001_7FFF);
    run_op(1, 0, 3'b000, 32'h100, 32'd0, 5'd13, 0, 3, 32'h1234_5680);
    run_op(1, 0, 3'b100, 32'h101, 32'd0, 5'd14, 0, 1, 32'h80FF_7F01);
    check32("lbu_b1_lit", last_wb_data, 32'h0000_007F);
    run_op(1, 0, 3'b001, 32'h203, 32'd0, 5'd15, 0, 1, 32'hF00D_1234);
    run_op(0, 1, 3'b010, 32'h402, 32'h0BAD_F00D, 5'd0, 0, 1, 32'd0);

    // No-op, both strobes, illegal load/store encodings
    run_op(0, 0, 3'b010, 32'h100, 32'd0, 5'd1, 0, 1, 32'd0);
    run_op(1, 1, 3'b010, 32'h100, 32'd0, 5'd1, 0, 1, 32'd0);
    run_op(1, 0, 3'b011, 32'h100, 32'd0, 5'd1, 0, 1, 32'd0);
    run_op(1, 0, 3'b110, 32'h100, 32'd0, 5'd1, 0, 1, 32'd0);
    run_op(0, 1, 3'b100, 32'h100, 32'd0, 5'd1, 0, 1, 32'd0);
    stray_rvalid(32'h0123_4567);

    // Reset while waiting for grant: request drops without a clock edge
    present(1, 0, 3'b010, 32'h300, 32'd0, 5'd3);
    idle_exp();
    step();
    clear_req();
    e_ready = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_be = 4'hF;
    step();
    #1 rst_n = 1'b0;
    #1;
    check32("async_req_drop", 32'(dmem_req), 32'd0);
    idle_exp();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Reset while waiting for read data, then a late response
    present(1, 0, 3'b010, 32'h304, 32'd0, 5'd4);
    idle_exp();
    step();
    clear_req();
    e_ready = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h304; e_be = 4'hF;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    e_req = 1'b0;
    #1 rst_n = 1'b0;
    idle_exp();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    last_wb_data = 32'h0;
    stray_rvalid(32'h7777_7777);
    check32("rst_no_wb", last_wb_data, 32'h0);
    check32("rst_ready_lit", 32'(req_ready), 32'd1);
    run_op(1, 0, 3'b010, 32'h308, 32'd0, 5'd6, 0, 1, 32'h0F0F_1234);
    check32("post_rst_lw_lit", last_wb_data, 32'h0F0F_1234);

    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage block directly downstream of the instruction decode/control unit and ALU. Accepts one load or store at a time, using the decoded `mem_read`/`mem_write` strobes, `funct3`, the ALU-computed address and the rs2 store data. Drives a request/grant/response data-memory bus with byte enables, and returns sign- or zero-extended load data to register writeback. A small FSM sequences the handshake and blocks further requests while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: width of `addr` and `dmem_addr`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage presents an operation.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `mem_read` in 1: load strobe from control.
- `mem_write` in 1: store strobe from control.
- `funct3` in 3: access size/sign (RV32I encoding).
- `addr` in ADDR_W: byte address from ALU.
- `store_data` in 32: rs2 value.
- `rd` in 5: destination register for loads.
- `dmem_req` out 1: bus request, held until grant.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-aligned write data.
- `dmem_gnt` in 1: memory accepts request this cycle.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read data word.
- `wb_valid` out 1: one-cycle pulse, load result valid.
- `wb_rd` out 5: load destination.
- `wb_data` out 32: extended load data.
- `done` out 1: one-cycle pulse per completed operation (load, store, no-op, error).
- `err` out 1: one-cycle pulse with `done` for illegal/misaligned operation.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: on `req_valid && req_ready`, register `addr`, `funct3`, `rd`, `store_data` and the op type. Neither strobe set → no-op, `done` next cycle. Both set, or `funct3` illegal for op (load: 000,001,010,100,101 legal; store: 000,001,010 legal) → `done`+`err` next cycle, no bus activity. Otherwise → REQ.
- REQ: `dmem_req`=1, all bus outputs stable until `dmem_gnt`. On grant: store → IDLE, `done` next cycle; load → RESP.
- RESP: wait for `dmem_rvalid`; capture and format; next cycle `wb_valid`=`done`=1, state IDLE.
- Store lanes: SB `dmem_be`=4'b0001<<addr[1:0], wdata = byte replicated x4; SH `dmem_be`=4'b0011<<{addr[1],1'b0}, wdata = half replicated x2; SW `dmem_be`=4'b1111. Loads drive `dmem_be`=4'b1111, `dmem_we`=0.
- Load format: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- `dmem_rvalid` outside RESP is ignored.

## Timing
- Reset: state IDLE; `req_ready`=1; `dmem_req`, `dmem_we`, `wb_valid`, `done`, `err`=0; `dmem_addr`, `dmem_be`, `dmem_wdata`, `wb_rd`, `wb_data`=0.
- All outputs registered; `req_ready` decoded from state.
- Accept at cycle T: `dmem_req` first high T+1. Zero-wait grant at T+1 and `dmem_rvalid` at T+2 → load `wb_valid` at T+3; store `done` at T+2. No-op/error `done` at T+1.
- `req_ready` low from T+1 until the cycle `done` pulses; a new request may be accepted in the `done` cycle.
- Memory guarantees `dmem_rvalid` no earlier than the cycle after grant; an unbounded wait in REQ/RESP is legal.
- `rst_n` low mid-operation: immediate return to IDLE, `dmem_req` drops asynchronously, pending result discarded, no `done`.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: halfword with addr[0]=1 or word with addr[1:0]≠0 → `done`+`err` at T+1, no bus request.
- Undefined: no check; halfword uses addr[1] only, word ignores addr[1:0] (forced alignment), no `err` from alignment.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, zero-wait → `dmem_addr`=0x100, `dmem_be`=4'hF, `wb_data`=0xDEADBEEF, `wb_rd` = request rd, `wb_valid` at T+3.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF7F01 → `wb_data`=0xFFFFFF80, then 0x00000080.
- SH addr 0x202, store_data 0x1234ABCD, grant delayed 3 cycles → `dmem_be`=4'b1100, `dmem_wdata`=0xABCDABCD held stable for all 4 REQ cycles, `done` the cycle after grant, no `wb_valid`.
- LW addr 0x101 → with macro: `err`+`done` at T+1, `dmem_req` never high; without macro: access to 0x100.
- Store with funct3=011 → `err`+`done` at T+1, no bus activity.
- Load in RESP, `rst_n` pulsed low, then late `dmem_rvalid` → no `wb_valid`, `req_ready`=1, next LW completes normally.
